// File: rtl/div.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero short-circuits to q = all ones, r = 0, dz = 1.
module div #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [M-1:0] b,
    input  logic         start,
    output logic [N-1:0] q,
    output logic [M-1:0] r,
    output logic         done,
    output logic         dz
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    dvd_q, dvd_d;
    logic [M-1:0]    dvs_q, dvs_d;
    logic [M-1:0]    prem_q, prem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    quo_q, quo_d;
    logic [M-1:0]    rem_q, rem_d;
    logic            dz_q, dz_d;

    logic [M:0]      p;
    logic [M-1:0]    diff;
    logic            ge;

    // p is the M+1-bit trial remainder; when p >= divisor the true difference is below
    // 2^M, so the low M bits of the subtraction are exact and prem never needs bit M.
    assign p    = {prem_q, dvd_q[N-1]};
    assign ge   = (p >= {1'b0, dvs_q});
    assign diff = p[M-1:0] - dvs_q;

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (b != '0) begin
                        dvd_d   = a;
                        dvs_d   = b;
                        prem_d  = '0;
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        quo_d   = '1;
                        rem_d   = '0;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                // Quotient bits fill the dividend register from the bottom as it drains.
                dvd_d  = {dvd_q[N-2:0], ge};
                prem_d = ge ? diff : p[M-1:0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    quo_d   = dvd_d;
                    rem_d   = prem_d;
                    dz_d    = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign q    = quo_q;
    assign r    = rem_q;
    assign dz   = dz_q;
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed scenarios plus randomized operands checked
// against plain integer division.
module tb_div;

    localparam int unsigned N = 16;
    localparam int unsigned M = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] a = '0;
    logic [M-1:0] b = '0;
    logic         start = 1'b0;
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         done;
    logic         dz;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    div #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .start (start),
        .q     (q),
        .r     (r),
        .done  (done),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    // Starts an operation and counts edges from capture (inclusive) until done is seen.
    task automatic run_op(input logic [N-1:0] av, input logic [M-1:0] bv, input bit keep,
                          output int edges);
        a     = av;
        b     = bv;
        start = 1'b1;
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (!keep) start = 1'b0;
            if (done) break;
        end
    endtask

    task automatic idle_edge();
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if ({q, r, done, dz} !== '0)
            $display("FAIL reset_outputs: got q=%0d r=%0d done=%b dz=%b, want all 0", q, r, done, dz);
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (done !== 1'b0) $display("FAIL reset_idle_done: got %b want 0", done);
        else pass_cnt++;
    endtask

    task automatic test_held_start();
        int edges;
        run_op(16'd12, 8'd4, 1'b1, edges);
        chk_cnt++;
        if (edges !== 17) $display("FAIL held_latency: got %0d edges want 17", edges);
        else pass_cnt++;
        chk_cnt++;
        if (q !== 16'd3 || r !== 8'd0 || dz !== 1'b0)
            $display("FAIL held_result: got q=%0d r=%0d dz=%b want q=3 r=0 dz=0", q, r, dz);
        else pass_cnt++;
        a = 16'd999;
        b = 8'd7;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (done !== 1'b1 || q !== 16'd3 || r !== 8'd0)
            $display("FAIL held_park: got done=%b q=%0d r=%0d want done=1 q=3 r=0", done, q, r);
        else pass_cnt++;
        idle_edge();
        chk_cnt++;
        if (done !== 1'b0) $display("FAIL held_release: got done=%b want 0", done);
        else pass_cnt++;
    endtask

    task automatic test_sequence();
        int edges;
        run_op(16'd100, 8'd7, 1'b0, edges);
        chk_cnt++;
        if (q !== 16'd14 || r !== 8'd2 || edges !== 17)
            $display("FAIL seq_100_7: got q=%0d r=%0d edges=%0d want q=14 r=2 edges=17", q, r, edges);
        else pass_cnt++;
        idle_edge();
        chk_cnt++;
        if (done !== 1'b0 || q !== 16'd14)
            $display("FAIL seq_gap: got done=%b q=%0d want done=0 q=14", done, q);
        else pass_cnt++;
        run_op(16'd65535, 8'd255, 1'b0, edges);
        chk_cnt++;
        if (q !== 16'd257 || r !== 8'd0 || dz !== 1'b0)
            $display("FAIL seq_65535_255: got q=%0d r=%0d dz=%b want q=257 r=0 dz=0", q, r, dz);
        else pass_cnt++;
        idle_edge();
    endtask

    task automatic test_boundaries();
        int edges;
        run_op(16'd7, 8'd9, 1'b0, edges);
        chk_cnt++;
        if (q !== 16'd0 || r !== 8'd7)
            $display("FAIL small_dividend: got q=%0d r=%0d want q=0 r=7", q, r);
        else pass_cnt++;
        idle_edge();
        run_op(16'd65535, 8'd1, 1'b0, edges);
        chk_cnt++;
        if (q !== 16'd65535 || r !== 8'd0)
            $display("FAIL unit_divisor: got q=%0d r=%0d want q=65535 r=0", q, r);
        else pass_cnt++;
        idle_edge();
    endtask

    task automatic test_div_zero();
        int edges;
        run_op(16'd50, 8'd0, 1'b0, edges);
        chk_cnt++;
        if (edges !== 1) $display("FAIL dz_latency: got %0d edges want 1", edges);
        else pass_cnt++;
        chk_cnt++;
        if (q !== 16'hFFFF || r !== 8'd0 || dz !== 1'b1)
            $display("FAIL dz_result: got q=%h r=%0d dz=%b want q=ffff r=0 dz=1", q, r, dz);
        else pass_cnt++;
        idle_edge();
        run_op(16'd50, 8'd5, 1'b0, edges);
        chk_cnt++;
        if (q !== 16'd10 || r !== 8'd0 || dz !== 1'b0)
            $display("FAIL dz_recover: got q=%0d r=%0d dz=%b want q=10 r=0 dz=0", q, r, dz);
        else pass_cnt++;
        idle_edge();
    endtask

    // Previous result is q=10 from test_div_zero.
    task automatic test_operand_change();
        int edges = 0;
        a     = 16'd1000;
        b     = 8'd3;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 5) begin
                a = 16'($urandom);
                b = 8'($urandom) | 8'd1;
                chk_cnt++;
                if (q !== 16'd10 || done !== 1'b0)
                    $display("FAIL hold_during_run: got q=%0d done=%b want q=10 done=0", q, done);
                else pass_cnt++;
            end
            if (done) break;
        end
        chk_cnt++;
        if (q !== 16'd333 || r !== 8'd1 || edges !== 17)
            $display("FAIL operand_change: got q=%0d r=%0d edges=%0d want q=333 r=1 edges=17",
                     q, r, edges);
        else pass_cnt++;
        idle_edge();
    endtask

    task automatic test_reset_abort();
        int edges;
        a     = 16'd1000;
        b     = 8'd3;
        start = 1'b1;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if ({q, r, done, dz} !== '0)
            $display("FAIL async_reset: got q=%0d r=%0d done=%b dz=%b want all 0", q, r, done, dz);
        else pass_cnt++;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (done !== 1'b0) $display("FAIL reset_hold: got done=%b want 0", done);
        else pass_cnt++;
        rst = 1'b0;
        run_op(16'd9, 8'd2, 1'b0, edges);
        chk_cnt++;
        if (q !== 16'd4 || r !== 8'd1 || edges !== 17)
            $display("FAIL after_abort: got q=%0d r=%0d edges=%0d want q=4 r=1 edges=17", q, r, edges);
        else pass_cnt++;
        idle_edge();
    endtask

    task automatic test_random();
        int edges;
        logic [N-1:0] av, exp_q;
        logic [M-1:0] bv, exp_r;
        logic         exp_dz;
        int           exp_edges;
        for (int i = 0; i < 30; i++) begin
            av = 16'($urandom);
            bv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if (bv == 0) begin
                exp_q = '1; exp_r = '0; exp_dz = 1'b1; exp_edges = 1;
            end else begin
                exp_q = av / bv; exp_r = 8'(av % bv); exp_dz = 1'b0; exp_edges = N + 1;
            end
            run_op(av, bv, 1'($urandom_range(0, 1)), edges);
            chk_cnt++;
            if (q !== exp_q || r !== exp_r || dz !== exp_dz || edges !== exp_edges)
                $display("FAIL random %0d/%0d: got q=%0d r=%0d dz=%b edges=%0d want q=%0d r=%0d dz=%b edges=%0d",
                         av, bv, q, r, dz, edges, exp_q, exp_r, exp_dz, exp_edges);
            else pass_cnt++;
            idle_edge();
        end
    endtask

    // Start toggled once per result; period must stay within N+3 edges.
    task automatic test_back_to_back();
        int edges;
        int period;
        for (int i = 0; i < 3; i++) begin
            logic [N-1:0] av = 16'($urandom);
            logic [M-1:0] bv = 8'($urandom) | 8'd1;
            run_op(av, bv, 1'b0, edges);
            idle_edge();
            period = edges + 1;
            chk_cnt++;
            if (q !== av / bv || r !== 8'(av % bv) || period > N + 3)
                $display("FAIL back_to_back %0d/%0d: got q=%0d r=%0d period=%0d want q=%0d r=%0d period<=%0d",
                         av, bv, q, r, period, av / bv, av % bv, N + 3);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_held_start();
        test_sequence();
        test_boundaries();
        test_div_zero();
        test_operand_change();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
